// File: rtl/plm_burst_reader_if.sv
// Bundles the command, output-stream and memory-port signals of the PLM burst reader.
// No logic inside; it only defines signal widths and directions.
// The reader side uses the slave modport, the command source/consumer/memory side uses master.
interface plm_burst_reader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 11
) ();
    // burst command
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;

    // read data stream
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              done;

    // BRAM port
    logic              mem_ce;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wem;
    logic [DATA_W-1:0] mem_d;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, out_ready, mem_q,
        output cmd_ready, out_valid, out_data, out_last, done,
        output mem_ce, mem_a, mem_we, mem_wem, mem_d
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_len, out_ready, mem_q,
        input  cmd_ready, out_valid, out_data, out_last, done,
        input  mem_ce, mem_a, mem_we, mem_wem, mem_d
    );
endinterface

// File: rtl/plm_burst_reader.sv
// Small synchronous FIFO with registered storage; head is visible while count != 0.
// Latency: a push at edge N is visible at the head after edge N.
// Backpressure: pop only when pop_rdy and non-empty; the caller guarantees no push when full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             head_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop      = pop_rdy && (cnt != '0);
    assign head_vld = (cnt != '0);
    assign head_dat = mem[rd_ptr];
    assign count    = cnt;

    // storage and write pointer; storage is cleared so the head reads 0 out of reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (push_vld) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= ptr_inc(wr_ptr);
        end
    end

    // read pointer advances on every accepted pop
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    // occupancy; simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else begin
            case ({push_vld, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// Burst read initiator: turns (addr, len) commands into a ready/valid word stream from one BRAM port.
// Latency: first word valid 2 cycles after command accept, then 1 word/cycle with out_ready held high.
// Backpressure: reads are issued only while buffered + in-flight words < 3, so out_ready never reaches mem_ce combinationally.
module plm_burst_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              rstn,
    plm_burst_reader_if.slave bus
);
    localparam int FIFO_DEPTH = 3;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        DRAIN     = 2'd2,
        DONE_ZERO = 2'd3
    } state_t;

    // one buffered word plus its end-of-burst marker
    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] dat;
    } beat_t;

    state_t            state;
    state_t            state_nxt;

    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued_q;
    logic              inflight_q;
    logic              inflight_last_q;
    logic              done_q;

    logic              accept;
    logic              issue;
    logic              issue_last;
    logic              pop;
    logic [CNT_W:0]    occupancy;

    logic              fifo_vld;
    beat_t             fifo_head;
    beat_t             fifo_push;
    logic [CNT_W-1:0]  fifo_cnt;

    assign accept     = (state == IDLE) && bus.cmd_valid;
    assign occupancy  = (CNT_W + 1)'(fifo_cnt) + (CNT_W + 1)'(inflight_q);
    assign issue      = (state == RUN) && (issued_q < len_q) &&
                        (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    assign issue_last = ((issued_q + LEN_W'(1)) == len_q);
    assign pop        = fifo_vld && bus.out_ready;

    assign fifo_push.last = inflight_last_q;
    assign fifo_push.dat  = bus.mem_q;

    sync_fifo #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push_vld (inflight_q),
        .push_dat (fifo_push),
        .pop_rdy  (bus.out_ready),
        .head_vld (fifo_vld),
        .head_dat (fifo_head),
        .count    (fifo_cnt)
    );

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state: RUN ends on the final issue, DRAIN ends on the final output handshake
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (bus.cmd_len == '0) ? DONE_ZERO : RUN;
                end
            end
            RUN: begin
                if (issue && issue_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && fifo_head.last) begin
                    state_nxt = IDLE;
                end
            end
            DONE_ZERO: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // burst address and issue counter; the address wraps naturally at 2^ADDR_W
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
        end else if (accept) begin
            addr_q   <= bus.cmd_addr;
            len_q    <= bus.cmd_len;
            issued_q <= '0;
        end else if (issue) begin
            addr_q   <= addr_q + ADDR_W'(1);
            issued_q <= issued_q + LEN_W'(1);
        end
    end

    // tracks the read whose data appears on mem_q this cycle, tagged if it is the burst's last word
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= issue && issue_last;
        end
    end

    // done pulses after the last beat handshakes, or right after a zero-length accept
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (accept && (bus.cmd_len == '0)) || (pop && fifo_head.last);
        end
    end

    // outputs; the write side of the memory port is permanently idle
    always_comb begin
        bus.cmd_ready = (state == IDLE);
        bus.out_valid = fifo_vld;
        bus.out_data  = fifo_head.dat;
        bus.out_last  = fifo_vld && fifo_head.last;
        bus.done      = done_q;
        bus.mem_ce    = issue;
        bus.mem_a     = addr_q;
        bus.mem_we    = 1'b0;
        bus.mem_wem   = '0;
        bus.mem_d     = '0;
    end
endmodule

// File: tb/tb_plm_burst_reader.sv
// Directed bench for plm_burst_reader with a registered-read BRAM model.
// Inputs are driven and outputs checked 1 time unit after the rising edge.
// A negedge monitor logs issues, beats and done pulses for cycle-accurate checks.
module tb_plm_burst_reader;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 11;

    logic clk;
    logic rstn;
    int   cyc;

    int n_checks;
    int n_errors;

    plm_burst_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus_if ();

    plm_burst_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_if)
    );

    // memory: mem[i] = i*3, one-cycle registered read
    logic [DATA_W-1:0] mem [1024];
    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 16'(i * 3);
        end
    end
    always @(posedge clk) begin
        if (bus_if.mem_ce) bus_if.mem_q <= mem[bus_if.mem_a];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // monitor logs
    int                acc_cyc;
    logic [ADDR_W-1:0] ce_addr [$];
    int                ce_cyc [$];
    logic [DATA_W-1:0] beat_dat [$];
    logic              beat_last [$];
    int                beat_cyc [$];
    int                done_cyc [$];
    int                issued_n, popped_n, max_out, stall_viol;
    logic              prev_stall;
    logic [DATA_W-1:0] prev_dat;
    logic              prev_last;

    // expected stream for the current burst
    logic [ADDR_W-1:0] exp_addr [$];
    logic [DATA_W-1:0] exp_dat [$];

    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (bus_if.cmd_valid && bus_if.cmd_ready) acc_cyc = cyc;
            if (bus_if.mem_ce) begin
                ce_addr.push_back(bus_if.mem_a);
                ce_cyc.push_back(cyc);
                issued_n++;
            end
            if (issued_n - popped_n > max_out) max_out = issued_n - popped_n;
            if (bus_if.out_valid && bus_if.out_ready) begin
                beat_dat.push_back(bus_if.out_data);
                beat_last.push_back(bus_if.out_last);
                beat_cyc.push_back(cyc);
                popped_n++;
            end
            if (bus_if.done) done_cyc.push_back(cyc);
            if (prev_stall && (!bus_if.out_valid || bus_if.out_data !== prev_dat ||
                               bus_if.out_last !== prev_last)) stall_viol++;
            prev_stall = bus_if.out_valid && !bus_if.out_ready;
            prev_dat   = bus_if.out_data;
            prev_last  = bus_if.out_last;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cyc_step();
    endtask

    task automatic clear_mon();
        acc_cyc = -100;
        ce_addr.delete(); ce_cyc.delete();
        beat_dat.delete(); beat_last.delete(); beat_cyc.delete();
        done_cyc.delete();
        issued_n = 0; popped_n = 0; max_out = 0; stall_viol = 0;
    endtask

    task automatic issue_cmd(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_addr  = a;
        bus_if.cmd_len   = l;
        cyc_step();
        bus_if.cmd_valid = 1'b0;
    endtask

    // compares the logged burst against exp_addr/exp_dat; exact adds cycle-position checks
    task automatic check_stream(input string tag, input bit exact);
        int n;
        n = exp_dat.size();
        check_eq({tag, "_ce_cnt"}, 32'(ce_addr.size()), 32'(n));
        check_eq({tag, "_beat_cnt"}, 32'(beat_dat.size()), 32'(n));
        check_eq({tag, "_done_cnt"}, 32'(done_cyc.size()), 32'd1);
        for (int k = 0; k < n; k++) begin
            if (k < ce_addr.size()) begin
                check_eq($sformatf("%s_addr%0d", tag, k), 32'(ce_addr[k]), 32'(exp_addr[k]));
                if (exact) check_eq($sformatf("%s_ce_cyc%0d", tag, k),
                                    32'(ce_cyc[k] - acc_cyc), 32'(1 + k));
            end
            if (k < beat_dat.size()) begin
                check_eq($sformatf("%s_dat%0d", tag, k), 32'(beat_dat[k]), 32'(exp_dat[k]));
                check_eq($sformatf("%s_last%0d", tag, k), 32'(beat_last[k]), 32'(k == n - 1));
                if (exact) check_eq($sformatf("%s_beat_cyc%0d", tag, k),
                                    32'(beat_cyc[k] - acc_cyc), 32'(3 + k));
            end
        end
        if (exact && done_cyc.size() > 0)
            check_eq({tag, "_done_cyc"}, 32'(done_cyc[0] - acc_cyc), 32'(3 + n));
        check_eq({tag, "_stall_viol"}, 32'(stall_viol), 32'd0);
        check_eq({tag, "_overfill"}, 32'(max_out > 3), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_cmd_ready"}, 32'(bus_if.cmd_ready), 32'd1);
        check_eq({tag, "_out_valid"}, 32'(bus_if.out_valid), 32'd0);
        check_eq({tag, "_mem_ce"},    32'(bus_if.mem_ce),    32'd0);
        check_eq({tag, "_done"},      32'(bus_if.done),      32'd0);
    endtask

    logic [39:0] rdy_pat;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rstn             = 1'b0;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_addr  = '0;
        bus_if.cmd_len   = '0;
        bus_if.out_ready = 1'b0;
        clear_mon();

        // reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            bus_if.cmd_valid = 1'($urandom_range(0, 1));
            bus_if.cmd_addr  = 10'($urandom);
            bus_if.cmd_len   = 11'($urandom);
            bus_if.out_ready = 1'($urandom_range(0, 1));
            cyc_step();
            check_reset_outputs($sformatf("rst%0d", i));
        end
        check_eq("rst_out_last", 32'(bus_if.out_last), 32'd0);
        check_eq("rst_out_data", 32'(bus_if.out_data), 32'd0);
        check_eq("rst_mem_a",    32'(bus_if.mem_a),    32'd0);
        check_eq("tie_we",       32'(bus_if.mem_we),   32'd0);
        check_eq("tie_wem",      32'(bus_if.mem_wem),  32'd0);
        check_eq("tie_d",        32'(bus_if.mem_d),    32'd0);

        // release with no command: stays idle
        bus_if.cmd_valid = 1'b0;
        bus_if.out_ready = 1'b1;
        rstn = 1'b1;
        run_cycles(4);
        check_reset_outputs("idle");

        // basic burst
        clear_mon();
        exp_addr = '{10'h010, 10'h011, 10'h012, 10'h013};
        exp_dat  = '{16'h0030, 16'h0033, 16'h0036, 16'h0039};
        issue_cmd(10'h010, 11'd4);
        run_cycles(12);
        check_stream("basic", 1'b1);

        // address wrap
        clear_mon();
        exp_addr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        exp_dat  = '{16'h0BFA, 16'h0BFD, 16'h0000, 16'h0003};
        issue_cmd(10'h3FE, 11'd4);
        run_cycles(12);
        check_stream("wrap", 1'b1);

        // backpressure: consumer stalled at first, then irregular
        clear_mon();
        exp_addr = '{10'h020, 10'h021, 10'h022, 10'h023, 10'h024, 10'h025, 10'h026, 10'h027};
        exp_dat  = '{16'h0060, 16'h0063, 16'h0066, 16'h0069,
                     16'h006C, 16'h006F, 16'h0072, 16'h0075};
        rdy_pat = 40'hFF_FF_A5_93_20;
        bus_if.out_ready = 1'b0;
        issue_cmd(10'h020, 11'd8);
        for (int i = 0; i < 40; i++) begin
            bus_if.out_ready = rdy_pat[i];
            cyc_step();
        end
        bus_if.out_ready = 1'b1;
        run_cycles(10);
        check_stream("bp", 1'b0);
        check_eq("bp_max_outstanding", 32'(max_out), 32'd3);

        // zero length
        clear_mon();
        issue_cmd(10'h055, 11'd0);
        run_cycles(6);
        check_eq("zero_ce_cnt",   32'(ce_addr.size()),  32'd0);
        check_eq("zero_beat_cnt", 32'(beat_dat.size()), 32'd0);
        check_eq("zero_done_cnt", 32'(done_cyc.size()), 32'd1);
        check_eq("zero_done_cyc",
                 32'((done_cyc.size() > 0) ? done_cyc[0] - acc_cyc : -1), 32'd1);

        // reset in the middle of a 16-word burst
        clear_mon();
        issue_cmd(10'h000, 11'd16);
        for (int i = 0; i < 40 && beat_dat.size() < 5; i++) cyc_step();
        check_eq("midrst_beats_seen", 32'(beat_dat.size()), 32'd5);
        rstn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        check_eq("midrst_out_last", 32'(bus_if.out_last), 32'd0);
        check_eq("midrst_out_data", 32'(bus_if.out_data), 32'd0);
        check_eq("midrst_mem_a",    32'(bus_if.mem_a),    32'd0);
        run_cycles(2);
        clear_mon();
        rstn = 1'b1;
        run_cycles(6);
        check_eq("post_rst_ce",   32'(ce_addr.size()),  32'd0);
        check_eq("post_rst_beat", 32'(beat_dat.size()), 32'd0);
        check_eq("post_rst_done", 32'(done_cyc.size()), 32'd0);

        clear_mon();
        exp_addr = '{10'h100, 10'h101};
        exp_dat  = '{16'h0300, 16'h0303};
        issue_cmd(10'h100, 11'd2);
        run_cycles(8);
        check_stream("after_rst", 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/plm_burst_reader.md
Name: plm_burst_reader

Overview:
- Read-side initiator for a 1024x16 dual-port PLM bank.
- Drives one BRAM port (CE/A/WE/WEM/D, returns Q with one-cycle registered read latency).
- Converts a burst command (start address, length) into a ready/valid data stream with full backpressure support, sustaining 1 word/cycle when the consumer is always ready.
- Sits between the accelerator datapath and the memory wrapper.

Parameters:
ADDR_W, 10, memory address width (depth 2^ADDR_W words)
DATA_W, 16, word width
LEN_W, 11, burst length width (max length 2^ADDR_W)

Ports:
clk  in  1  clock, rising-edge
rstn  in  1  asynchronous active-low reset
cmd_valid  in  1  burst command valid
cmd_ready  out  1  block can accept command
cmd_addr  in  ADDR_W  start address
cmd_len  in  LEN_W  number of words (0 legal)
out_valid  out  1  stream data valid
out_ready  in  1  consumer accepts data
out_data  out  DATA_W  read word
out_last  out  1  final word of burst
done  out  1  one-cycle pulse, burst complete
mem_ce  out  1  memory port enable
mem_a  out  ADDR_W  memory address
mem_we  out  1  write enable, tied 0
mem_wem  out  DATA_W  write mask, tied 0
mem_d  out  DATA_W  write data, tied 0
mem_q  in  DATA_W  read data, valid cycle after mem_ce

Behaviour:
- Reset: asynchronous on rstn low. Clears state to IDLE, FIFO to empty, in-flight flag, counters.
  - Reset values: cmd_ready=1, out_valid=0, out_last=0, done=0, mem_ce=0, mem_a=0, out_data=0.
- Tied outputs: mem_we, mem_wem and mem_d are constant 0.
- States:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch addr and len.
    - len!=0 -> RUN.
    - len==0 -> DONE_ZERO.
  - RUN: issue reads until issued count == len, then -> DRAIN.
  - DRAIN: no issue. When the last word handshakes on out, pulse done and go to IDLE.
  - DONE_ZERO: done=1 for one cycle, no memory access, no out beat; -> IDLE.
- cmd_ready is 0 in every state except IDLE.
- Issue rule (registered, no combinational path from out_ready to mem_ce): mem_ce=1 in a cycle iff state==RUN, issued<len, and fifo_count + inflight < 3.
  - mem_a = current address.
  - Address increments mod 2^ADDR_W per issue: 1023 -> 0 wrap is legal and required.
- Capture: inflight is set the cycle after mem_ce=1. mem_q is pushed into a 3-entry FIFO at the end of that cycle. The FIFO never overflows by construction.
- Output:
  - out_valid = FIFO non-empty; out_data = FIFO head (registered storage).
  - Pop on out_valid&out_ready.
  - out_data and out_last hold stable while out_valid&!out_ready.
- Latency: command accepted at edge E0 -> mem_ce in cycle after E0 -> first out_valid after edge E2, i.e. 2 cycles.
  - With out_ready=1 continuously, one word/cycle; a burst of N completes its last handshake N+1 cycles after acceptance.
- out_last=1 exactly on the beat whose index == len-1; 0 otherwise.
- done: one-cycle pulse in the cycle after the last beat's handshake. A new command is accepted at the earliest in that same cycle (state IDLE).
- Simultaneous push and pop on the FIFO in one cycle: count unchanged, order preserved.
- Reset mid-burst: in-flight read data is discarded, and no beat or done appears after rstn deasserts.
- cmd_len > 2^ADDR_W: out of contract; behaviour is wrap-around reads.

Test Plan:
- Reset: hold rstn=0 with random inputs -> cmd_ready=1, out_valid=0, mem_ce=0, done=0. Release with no command -> all stay idle.
- Basic burst: addr=0x010, len=4, out_ready=1, memory preloaded mem[i]=i*3.
  - Expect mem_a 0x010..0x013 on 4 consecutive cycles.
  - Expect out_data 0x30,0x33,0x36,0x39 back-to-back, first 2 cycles after accept.
  - Expect out_last on 4th beat; done on the following cycle.
- Wrap: addr=0x3FE, len=4 -> mem_a 0x3FE,0x3FF,0x000,0x001. Data order matches memory contents.
- Backpressure: len=8, out_ready toggling 1,0,0,1,... random pattern.
  - All 8 words delivered in order with no loss or duplication.
  - out_data stable while stalled.
  - Never more than 3 words buffered plus in flight.
- Zero length: len=0 -> no mem_ce, no out_valid, done pulses exactly once the cycle after acceptance.
- Reset mid-burst: len=16, assert rstn=0 after 5 beats -> outputs return to reset values immediately. New burst addr=0x100, len=2 then completes correctly with no stale data.
